// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: store size encoding and the queued entry format.
package HighLevelControl;

    // Entry width; the store_buffer XLEN parameter is expected to match it.
    localparam int SB_XLEN = 32;

    typedef enum logic [1:0] {
        BYTE      = 2'd0,
        HALF_WORD = 2'd1,
        WORD      = 2'd2
    } storeSize;

    typedef struct packed {
        logic [SB_XLEN-1:0]   addr;
        logic [SB_XLEN-1:0]   wdata;
        logic [SB_XLEN/8-1:0] wmask;
    } sbEntry;

endpackage

// File: rtl/store_buffer_if.sv
// Store-side (MEM stage) and memory-side handshake bundle of the store buffer.
// slave: the store buffer itself. master: the pipeline/memory environment around it.
interface store_buffer_if #(
    parameter int XLEN = 32
);
    logic                         st_valid;
    logic                         st_ready;
    logic [XLEN-1:0]              st_addr;
    logic [XLEN-1:0]              st_data;
    HighLevelControl::storeSize   st_size;

    logic                         mem_req;
    logic [XLEN-1:0]              mem_addr;
    logic [XLEN-1:0]              mem_wdata;
    logic [XLEN/8-1:0]            mem_wmask;
    logic                         mem_ack;

    modport slave (
        input  st_valid, st_addr, st_data, st_size, mem_ack,
        output st_ready, mem_req, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output st_valid, st_addr, st_data, st_size, mem_ack,
        input  st_ready, mem_req, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/store_buffer_align.sv
// store_align: combinational lane shifter turning an LSB-justified store into a
// word-aligned address, replicated write data and byte mask, and flagging misalignment.
module store_align
    import HighLevelControl::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   data,
    input  storeSize          size,
    output logic [XLEN-1:0]   word_addr,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN/8-1:0] wmask,
    output logic              misaligned
);
    localparam int LANES = XLEN / 8;
    localparam int OFF_W = $clog2(LANES);

    logic [OFF_W-1:0] off;
    assign off = addr[OFF_W-1:0];

    // Replicate data across lanes and select the byte enables for the addressed lanes.
    always_comb begin
        // Clearing every low bit also covers the HALF [0] / WORD [1:0] clearing rule.
        word_addr  = {addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
        wdata      = data;
        wmask      = '1;
        misaligned = 1'b0;
        case (size)
            BYTE: begin
                wdata = {LANES{data[7:0]}};
                wmask = LANES'(1) << off;
            end
            HALF_WORD: begin
                wdata      = {(LANES/2){data[15:0]}};
                wmask      = LANES'(3) << {off[OFF_W-1:1], 1'b0};
                misaligned = off[0];
            end
            default: begin
                // WORD (and the unused encoding) writes the full word.
                wdata      = data;
                wmask      = '1;
                misaligned = (off != '0);
            end
        endcase
    end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order store queue between the MEM stage and data memory.
// Stores are formatted on the push path, queued in a DEPTH-entry FIFO and drained
// over a req/ack handshake; the pipeline only stalls when the FIFO is full.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned stores are dropped and
// reported through misalign_fault/fault_addr instead of being force-aligned).
module store_buffer
    import HighLevelControl::*;
#(
    parameter int XLEN  = SB_XLEN,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    store_buffer_if.slave   sb,
    output logic            sb_empty
`ifdef MISALIGN_TRAP_EN
    ,
    output logic            misalign_fault,
    output logic [XLEN-1:0] fault_addr
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    sbEntry           entries_q [DEPTH];
    sbEntry           entry_d;

    logic [XLEN-1:0]   al_addr;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN/8-1:0] al_wmask;
    logic              al_misaligned;

    logic push, enq, pop;

`ifdef MISALIGN_TRAP_EN
    logic            fault_q, fault_d;
    logic [XLEN-1:0] fault_addr_q, fault_addr_d;
`endif

    store_align #(.XLEN(XLEN)) u_align (
        .addr       (sb.st_addr),
        .data       (sb.st_data),
        .size       (sb.st_size),
        .word_addr  (al_addr),
        .wdata      (al_wdata),
        .wmask      (al_wmask),
        .misaligned (al_misaligned)
    );

    // Ready depends on count only, so it never waits on mem_ack combinationally.
    assign sb.st_ready  = (count_q != CNT_W'(DEPTH));
    assign sb.mem_req   = (count_q != '0);
    assign sb_empty     = (count_q == '0);
    assign sb.mem_addr  = entries_q[rd_ptr_q].addr;
    assign sb.mem_wdata = entries_q[rd_ptr_q].wdata;
    assign sb.mem_wmask = entries_q[rd_ptr_q].wmask;

`ifdef MISALIGN_TRAP_EN
    assign misalign_fault = fault_q;
    assign fault_addr     = fault_addr_q;
`endif

    // Handshake decode, pointer/count next state and the formatted entry to enqueue.
    always_comb begin
        push    = sb.st_valid && sb.st_ready;
        // A trapped misaligned store is consumed but never enqueued.
        enq     = push && !(TRAP_EN && al_misaligned);
        pop     = sb.mem_req && sb.mem_ack;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        entry_d.addr  = al_addr;
        entry_d.wdata = al_wdata;
        entry_d.wmask = al_wmask;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (enq && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !enq) begin
            count_d = count_q - CNT_W'(1);
        end
`ifdef MISALIGN_TRAP_EN
        fault_d      = push && al_misaligned;
        fault_addr_d = (push && al_misaligned) ? sb.st_addr : fault_addr_q;
`endif
    end

    // Control state: pointers, occupancy and the fault pulse; reset drops all entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifdef MISALIGN_TRAP_EN
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
`ifdef MISALIGN_TRAP_EN
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
`endif
        end
    end

    // Entry storage; contents are only meaningful while count covers them, so no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            entries_q[wr_ptr_q] <= entry_d;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed + randomized bench for store_buffer with a queue-based reference model.
// Covers the MISALIGN_TRAP_EN build as well when the macro is defined.
module tb_store_buffer;
    import HighLevelControl::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    logic sb_empty;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_fault;
    logic [31:0] fault_addr;
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    store_buffer_if #(.XLEN(XLEN)) sbif ();

    store_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .sb             (sbif.slave),
        .sb_empty       (sb_empty)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign_fault (misalign_fault),
        .fault_addr     (fault_addr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    bit          exp_fault = 1'b0;
    logic [31:0] exp_faddr = '0;
    bit          acc;

    function automatic bit is_mis(logic [31:0] a, storeSize s);
        if (s == HALF_WORD) return (a % 2) != 0;
        if (s == WORD)      return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic exp_t fmt(logic [31:0] a, logic [31:0] d, storeSize s);
        exp_t e;
        e.addr = a - (a % 4);
        case (s)
            BYTE: begin
                e.wdata = (d % 256) * 32'h0101_0101;
                e.wmask = 4'(1 << (a % 4));
            end
            HALF_WORD: begin
                e.wdata = (d % 65536) * 32'h0001_0001;
                e.wmask = ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
            end
            default: begin
                e.wdata = d;
                e.wmask = 4'b1111;
            end
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] d,
                         input storeSize s, input bit ack);
        sbif.st_valid = v;
        sbif.st_addr  = a;
        sbif.st_data  = d;
        sbif.st_size  = s;
        sbif.mem_ack  = ack;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic step(output bit accepted);
        bit          do_pop;
        logic [31:0] a, d;
        storeSize    s;
        @(negedge clk);
        chk("mem_req", 32'(sbif.mem_req), 32'(q.size() != 0));
        chk("sb_empty", 32'(sb_empty), 32'(q.size() == 0));
        chk("st_ready", 32'(sbif.st_ready), 32'(q.size() < DEPTH));
        if (q.size() != 0) begin
            chk("mem_addr", sbif.mem_addr, q[0].addr);
            chk("mem_wdata", sbif.mem_wdata, q[0].wdata);
            chk("mem_wmask", 32'(sbif.mem_wmask), 32'(q[0].wmask));
        end
`ifdef MISALIGN_TRAP_EN
        chk("misalign_fault", 32'(misalign_fault), 32'(exp_fault));
        if (exp_fault) chk("fault_addr", fault_addr, exp_faddr);
`endif
        do_pop   = (q.size() != 0) && sbif.mem_ack;
        accepted = sbif.st_valid && (q.size() < DEPTH);
        a = sbif.st_addr;
        d = sbif.st_data;
        s = sbif.st_size;
        @(posedge clk);
        #1;
        exp_fault = 1'b0;
        if (do_pop) void'(q.pop_front());
        if (accepted) begin
            if (TRAP && is_mis(a, s)) begin
                exp_fault = 1'b1;
                exp_faddr = a;
            end else begin
                q.push_back(fmt(a, d, s));
            end
        end
    endtask

    task automatic drain(input string tag);
        bit a;
        drive(0, '0, '0, BYTE, 1);
        for (int i = 0; i < 20 && q.size() != 0; i++) step(a);
        chk({tag, "_drained"}, 32'(q.size()), 32'd0);
        step(a);
    endtask

    initial begin
        drive(0, '0, '0, BYTE, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_mem_req", 32'(sbif.mem_req), 32'd0);
        chk("rst_sb_empty", 32'(sb_empty), 32'd1);
        chk("rst_st_ready", 32'(sbif.st_ready), 32'd1);
`ifdef MISALIGN_TRAP_EN
        chk("rst_fault", 32'(misalign_fault), 32'd0);
        chk("rst_fault_addr", fault_addr, 32'd0);
`endif

        // BYTE 0xA5 @0x1003 with ack held high
        drive(1, 32'h1003, 32'h0000_00A5, BYTE, 1);
        step(acc);
        chk("b_req", 32'(sbif.mem_req), 32'd1);
        chk("b_addr", sbif.mem_addr, 32'h1000);
        chk("b_wdata", sbif.mem_wdata, 32'hA5A5_A5A5);
        chk("b_wmask", 32'(sbif.mem_wmask), 32'h8);
        drive(0, '0, '0, BYTE, 1);
        step(acc);
        chk("b_empty", 32'(sb_empty), 32'd1);

        // HALF then WORD back to back
        drive(1, 32'h2002, 32'h0000_BEEF, HALF_WORD, 0);
        step(acc);
        drive(1, 32'h2004, 32'h1234_5678, WORD, 0);
        step(acc);
        chk("h_wmask", 32'(sbif.mem_wmask), 32'hC);
        chk("h_wdata", sbif.mem_wdata, 32'hBEEF_BEEF);
        drive(0, '0, '0, BYTE, 1);
        step(acc);
        chk("w_wmask", 32'(sbif.mem_wmask), 32'hF);
        chk("w_addr", sbif.mem_addr, 32'h2004);
        chk("w_wdata", sbif.mem_wdata, 32'h1234_5678);
        step(acc);
        chk("hw_empty", 32'(sb_empty), 32'd1);

        // Fill with ack low, hold a 5th store, then drain
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, $urandom & 32'hFFFF_FFFC, $urandom, storeSize'($urandom_range(0, 2)), 0);
            step(acc);
        end
        chk("full_ready", 32'(sbif.st_ready), 32'd0);
        drive(1, 32'h4000, 32'hCAFE_F00D, WORD, 0);
        step(acc);
        chk("full_hold0", 32'(acc), 32'd0);
        step(acc);
        chk("full_hold1", 32'(acc), 32'd0);
        sbif.mem_ack = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) step(acc);
        chk("fifth_accepted", 32'(acc), 32'd1);
        drain("fill");

        // Steady state at two entries: push and ack together
        for (int i = 0; i < 2; i++) begin
            drive(1, $urandom, $urandom, BYTE, 0);
            step(acc);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, $urandom & 32'hFFFF_FFFC, $urandom, storeSize'($urandom_range(0, 2)), 1);
            step(acc);
            chk("steady_acc", 32'(acc), 32'd1);
            chk("steady_cnt", 32'(q.size()), 32'd2);
        end
        drain("steady");

        // Misaligned WORD @0x3001
        drive(1, 32'h3001, 32'h55AA_66BB, WORD, 0);
        step(acc);
`ifdef MISALIGN_TRAP_EN
        chk("mis_fault", 32'(misalign_fault), 32'd1);
        chk("mis_faddr", fault_addr, 32'h3001);
        chk("mis_req", 32'(sbif.mem_req), 32'd0);
        drive(0, '0, '0, BYTE, 0);
        step(acc);
        chk("mis_pulse_end", 32'(misalign_fault), 32'd0);
        chk("mis_req2", 32'(sbif.mem_req), 32'd0);
`else
        chk("mis_addr", sbif.mem_addr, 32'h3000);
        chk("mis_wmask", 32'(sbif.mem_wmask), 32'hF);
        chk("mis_wdata", sbif.mem_wdata, 32'h55AA_66BB);
`endif
        drain("mis");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, $urandom,
                  storeSize'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            step(acc);
        end
        drain("rand");

        // Reset with three entries pending
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h5000 + 32'(4 * i), $urandom, WORD, 0);
            step(acc);
        end
        chk("pre_rst_req", 32'(sbif.mem_req), 32'd1);
        drive(0, '0, '0, BYTE, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        exp_fault = 1'b0;
        chk("mrst_req", 32'(sbif.mem_req), 32'd0);
        chk("mrst_empty", 32'(sb_empty), 32'd1);
        chk("mrst_ready", 32'(sbif.st_ready), 32'd1);
        sbif.mem_ack = 1'b1;
        step(acc);
        step(acc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
